// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared arbiter state type and round-robin pointer width helper
package spi_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVATE, S_AWAIT, S_DONE} state_t;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: arbiter-to-SPI-controller bus (master = arbiter, slave = controller)
interface spi_txn_arbiter_if #(
    parameter int OUT_BYTES   = 5,
    parameter int IN_BYTES    = 4,
    parameter int NUM_SELECTS = 1
);
    logic                             activate;
    logic [OUT_BYTES*8-1:0]           out_data;
    logic [$clog2(OUT_BYTES+1)-1:0]   out_count;
    logic [$clog2(IN_BYTES+1)-1:0]    in_count;
    logic [NUM_SELECTS-1:0]           in_cs;
    logic                             busy;
    logic [IN_BYTES*8-1:0]            in_data;

    modport master (output activate, out_data, out_count, in_count, in_cs, input busy, in_data);
    modport slave  (input activate, out_data, out_count, in_count, in_cs, output busy, in_data);
endinterface

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker, first set req at or after ptr wins (one-hot)
module rr_select import spi_arb_pkg::*; #(
    parameter int N  = 2,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);
    logic [PW:0]   s;
    logic [PW-1:0] k;

    // scan offsets from farthest to nearest so the nearest requester overwrites the rest
    always_comb begin
        win = '0;
        s   = '0;
        k   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            s = {1'b0, ptr} + (PW+1)'(i);
            k = (s >= (PW+1)'(N)) ? PW'(s - (PW+1)'(N)) : PW'(s);
            if (req[k]) begin
                win    = '0;
                win[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter sharing one SPI controller among NUM_REQ requesters
// Optional: define SPI_ARB_TIMEOUT_EN to add a timeout output and abort when busy never rises.
module spi_txn_arbiter import spi_arb_pkg::*; #(
    parameter int NUM_REQ        = 2,
    parameter int OUT_BYTES      = 5,
    parameter int IN_BYTES       = 4,
    parameter int NUM_SELECTS    = 1,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int OCW = $clog2(OUT_BYTES + 1),
    localparam int ICW = $clog2(IN_BYTES + 1),
    localparam int PW  = ptr_width(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req,
    input  logic [NUM_REQ-1:0][OUT_BYTES*8-1:0]    req_out_data,
    input  logic [NUM_REQ-1:0][OCW-1:0]            req_out_count,
    input  logic [NUM_REQ-1:0][ICW-1:0]            req_in_count,
    input  logic [NUM_REQ-1:0][NUM_SELECTS-1:0]    req_cs,
    output logic [NUM_REQ-1:0]                     done,
    output logic [IN_BYTES*8-1:0]                  rd_data,
    output logic [NUM_REQ-1:0]                     grant,
`ifdef SPI_ARB_TIMEOUT_EN
    output logic                                   timeout,
`endif
    spi_txn_arbiter_if.master                      ctrl
);
    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("spi_txn_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES at least 1");
    end

    state_t               state, state_n;
    logic [PW-1:0]        ptr, win_idx;
    logic [NUM_REQ-1:0]   win;
    logic                 load, cap;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]        tcnt;
    logic                 expire;
`endif

    rr_select #(.N(NUM_REQ), .PW(PW)) u_sel (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    // one-hot winner to index for data muxing and pointer advance
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win[i]) win_idx = PW'(i);
    end

    // next state and single-cycle control strobes
    always_comb begin
        state_n = state;
        load    = 1'b0;
        cap     = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        expire  = 1'b0;
`endif
        case (state)
            S_IDLE: if (|req && !ctrl.busy) begin
                state_n = S_ACTIVATE;
                load    = 1'b1;
            end
            S_ACTIVATE: if (ctrl.busy) state_n = S_AWAIT;
`ifdef SPI_ARB_TIMEOUT_EN
            else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n = S_DONE;
                expire  = 1'b1;
            end
`endif
            S_AWAIT: if (!ctrl.busy) begin
                state_n = S_DONE;
                cap     = 1'b1;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? S_IDLE : state_n;
    end

    // controller outputs, grant, completion and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr            <= '0;
            grant          <= '0;
            done           <= '0;
            rd_data        <= '0;
            ctrl.activate  <= 1'b0;
            ctrl.out_data  <= '0;
            ctrl.out_count <= '0;
            ctrl.in_count  <= '0;
            ctrl.in_cs     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt           <= '0;
            timeout        <= 1'b0;
`endif
        end else begin
            done <= '0;
            if (load) begin
                grant          <= win;
                ptr            <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                ctrl.activate  <= 1'b1;
                ctrl.out_data  <= req_out_data[win_idx];
                ctrl.out_count <= req_out_count[win_idx];
                ctrl.in_count  <= req_in_count[win_idx];
                ctrl.in_cs     <= req_cs[win_idx];
            end
            if (state == S_ACTIVATE && ctrl.busy) ctrl.activate <= 1'b0;
            if (cap) begin
                rd_data <= ctrl.in_data;
                done    <= grant;
            end
            if (state == S_DONE) grant <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tcnt    <= (state == S_ACTIVATE) ? tcnt + 1'b1 : '0;
            timeout <= expire;
            if (expire) begin
                ctrl.activate <= 1'b0;
                done          <= grant;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// tb_spi_txn_arbiter: table, hand-written and randomized checks with a behavioural SPI controller
module tb_spi_txn_arbiter;
    localparam int NR = 2;
    localparam int OB = 5;
    localparam int IB = 4;
    localparam int NS = 1;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NR-1:0]            req = '0;
    logic [NR-1:0][OB*8-1:0]  req_out_data = '0;
    logic [NR-1:0][2:0]       req_out_count = '0;
    logic [NR-1:0][2:0]       req_in_count = '0;
    logic [NR-1:0][NS-1:0]    req_cs = '0;
    logic [NR-1:0]            done, grant;
    logic [IB*8-1:0]          rd_data;
`ifdef SPI_ARB_TIMEOUT_EN
    logic                     timeout;
`endif

    int checks = 0;
    int errors = 0;

    spi_txn_arbiter_if #(.OUT_BYTES(OB), .IN_BYTES(IB), .NUM_SELECTS(NS)) ctrl_if ();

    spi_txn_arbiter #(.NUM_REQ(NR), .OUT_BYTES(OB), .IN_BYTES(IB), .NUM_SELECTS(NS), .TIMEOUT_CYCLES(10)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_out_data  (req_out_data),
        .req_out_count (req_out_count),
        .req_in_count  (req_in_count),
        .req_cs        (req_cs),
        .done          (done),
        .rd_data       (rd_data),
        .grant         (grant),
`ifdef SPI_ARB_TIMEOUT_EN
        .timeout       (timeout),
`endif
        .ctrl          (ctrl_if)
    );

    always #5 clk = ~clk;

    // behavioural SPI controller: busy rises rise_dly cycles after activate, stays hold cycles
    int          rise_dly = 2;
    int          hold = 5;
    int          phase, cnt;
    logic        m_busy;
    logic        ext_busy = 1'b0;
    logic [31:0] rsp = '0;

    assign ctrl_if.busy = m_busy | ext_busy;

    always @(posedge clk) begin
        if (reset) begin
            phase <= 0;
            cnt <= 0;
            m_busy <= 1'b0;
            ctrl_if.in_data <= '0;
        end else begin
            case (phase)
                0: if (ctrl_if.activate) begin
                    phase <= 1;
                    cnt <= rise_dly - 1;
                end
                1: if (rise_dly == 0) begin
                    if (!ctrl_if.activate) phase <= 0;
                end else if (cnt <= 1) begin
                    m_busy <= 1'b1;
                    phase <= 2;
                    cnt <= hold;
                end else cnt <= cnt - 1;
                default: if (cnt <= 1) begin
                    m_busy <= 1'b0;
                    ctrl_if.in_data <= rsp;
                    phase <= 0;
                end else cnt <= cnt - 1;
            endcase
        end
    end

    // reference model: round-robin pointer kept as a plain integer
    int ptr_m = 0;

    function automatic int pick(input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++)
            if (r[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        ext_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ptr_m = 0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_await(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grant != '0 && !ctrl_if.activate && ctrl_if.busy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // one full transaction: randomize requester payloads, expect winner w, response d
    task automatic txn(input logic [NR-1:0] r, input logic [31:0] d, input int w);
        int lat;
        bit ok;
        for (int i = 0; i < NR; i++) begin
            req_out_data[i]  = {8'($urandom), $urandom};
            req_out_count[i] = 3'($urandom_range(OB));
            req_in_count[i]  = 3'($urandom_range(IB));
            req_cs[i]        = NS'($urandom);
        end
        rsp = d;
        req = r;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (grant == '0 && lat < 100);
        chk("latency", 64'(lat), 64'd1);
        chk("grant", 64'(grant), 64'(1 << w));
        chk("activate", 64'(ctrl_if.activate), 64'd1);
        chk("out_data", 64'(ctrl_if.out_data), 64'(req_out_data[w]));
        chk("out_count", 64'(ctrl_if.out_count), 64'(req_out_count[w]));
        chk("in_count", 64'(ctrl_if.in_count), 64'(req_in_count[w]));
        chk("in_cs", 64'(ctrl_if.in_cs), 64'(req_cs[w]));
        ptr_m = (w + 1) % NR;
        wait_done(ok);
        chk("done_seen", 64'(ok), 64'd1);
        chk("done", 64'(done), 64'(1 << w));
        chk("rd_data", 64'(rd_data), 64'(d));
        chk("held_data", 64'(ctrl_if.out_data), 64'(req_out_data[w]));
        req = '0;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("grant_idle", 64'(grant), 64'd0);
    endtask

    typedef struct {
        logic [NR-1:0] r;
        int            w;
        logic [31:0]   d;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit ok;
        int n;
        logic [NR-1:0] r;
        logic [NR-1:0] seen[$];

        tbl[0] = '{2'b01, 0, 32'h1111_0001};
        tbl[1] = '{2'b11, 1, 32'h2222_0002};
        tbl[2] = '{2'b11, 0, 32'h3333_0003};
        tbl[3] = '{2'b10, 1, 32'h4444_0004};
        tbl[4] = '{2'b10, 1, 32'h5555_0005};
        tbl[5] = '{2'b01, 0, 32'h6666_0006};
        tbl[6] = '{2'b11, 1, 32'h7777_0007};
        tbl[7] = '{2'b11, 0, 32'h8888_0008};

        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_activate", 64'(ctrl_if.activate), 64'd0);
        chk("rst_out_data", 64'(ctrl_if.out_data), 64'd0);
        chk("rst_counts", 64'({ctrl_if.out_count, ctrl_if.in_count, ctrl_if.in_cs}), 64'd0);
        reset = 1'b0;
        ptr_m = 0;

        // table-driven round-robin sequence from reset
        for (int i = 0; i < 8; i++) txn(tbl[i].r, tbl[i].d, tbl[i].w);

        // single request, busy rises 2 cycles after activate and holds 40
        do_reset();
        rise_dly = 2;
        hold = 40;
        rsp = 32'hDEAD_BEEF;
        req = 2'b01;
        @(negedge clk);
        chk("c1_activate", 64'(ctrl_if.activate), 64'd1);
        chk("c1_grant", 64'(grant), 64'd1);
        repeat (2) @(negedge clk);
        chk("c3_activate_held", 64'(ctrl_if.activate), 64'd1);
        @(negedge clk);
        chk("c4_activate_drop", 64'(ctrl_if.activate), 64'd0);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (done != '0) begin
                chk("deadbeef_done", 64'(done), 64'd1);
                chk("deadbeef_rd", 64'(rd_data), 64'hDEAD_BEEF);
                req = '0;
                n++;
            end
            @(negedge clk);
        end
        chk("deadbeef_pulses", 64'(n), 64'd1);
        chk("deadbeef_grant", 64'(grant), 64'd0);

        // both requesters held through four transactions
        do_reset();
        hold = 3;
        req = 2'b11;
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            @(negedge clk);
            if (grant != '0 && (seen.size() == n)) seen.push_back(grant);
            if (done != '0) begin
                n++;
                if (n == 4) req = '0;
            end
        end
        chk("rr4_pulses", 64'(n), 64'd4);
        chk("rr4_starts", 64'(seen.size()), 64'd4);
        for (int i = 0; i < seen.size() && i < 4; i++)
            chk("rr4_order", 64'(seen[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        @(negedge clk);

        // external busy blocks granting
        do_reset();
        ext_busy = 1'b1;
        req = 2'b10;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (grant != '0) n++;
        end
        chk("busy_no_grant", 64'(n), 64'd0);
        ext_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_grant", 64'(grant), 64'd2);
        wait_done(ok);
        chk("busy_release_done", 64'(done), 64'd2);
        req = '0;
        @(negedge clk);

        // request dropped while awaiting busy fall
        do_reset();
        hold = 6;
        rsp = 32'hCAFE_0032;
        req = 2'b01;
        wait_await(ok);
        chk("drop_reach_await", 64'(ok), 64'd1);
        req = '0;
        wait_done(ok);
        chk("drop_done", 64'(done), 64'd1);
        chk("drop_rd", 64'(rd_data), 64'hCAFE_0032);
        @(negedge clk);

        // reset during await abandons the transaction
        do_reset();
        req = 2'b01;
        wait_await(ok);
        chk("rst_reach_await", 64'(ok), 64'd1);
        reset = 1'b1;
        req = '0;
        @(negedge clk);
        chk("mid_rst_outputs", 64'({grant, done, ctrl_if.activate}), 64'd0);
        chk("mid_rst_data", 64'({rd_data, ctrl_if.out_count, ctrl_if.in_count, ctrl_if.in_cs}), 64'd0);
        chk("mid_rst_out_data", 64'(ctrl_if.out_data), 64'd0);
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done != '0) n++;
        end
        chk("mid_rst_no_done", 64'(n), 64'd0);
        ptr_m = 0;
        txn(2'b11, 32'h0BAD_F00D, 0);

        // randomized transactions against the round-robin model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            r = NR'($urandom_range(1, (1 << NR) - 1));
            rise_dly = $urandom_range(2, 4);
            hold = $urandom_range(1, 6);
            txn(r, $urandom, pick(r));
        end

`ifdef SPI_ARB_TIMEOUT_EN
        // busy never rises: abort after ten waiting cycles
        do_reset();
        rise_dly = 0;
        req = 2'b01;
        @(negedge clk);
        chk("to_c1_activate", 64'(ctrl_if.activate), 64'd1);
        for (int c = 2; c <= 11; c++) begin
            @(negedge clk);
            if (c == 10) chk("to_c10_quiet", 64'({done, timeout}), 64'd0);
        end
        chk("to_done", 64'(done), 64'd1);
        chk("to_timeout", 64'(timeout), 64'd1);
        chk("to_activate", 64'(ctrl_if.activate), 64'd0);
        req = '0;
        @(negedge clk);
        chk("to_pulse", 64'({done, timeout}), 64'd0);
        rise_dly = 2;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
